decade_display: RTL

Downstream consumer of `decade_counter`'s `out` signal. Counts rising edges of that signal in a DIGITS-wide BCD accumulator, with a sticky overflow flag. Shows the count on a time-multiplexed, active-low seven-segment display. Provides synchronous clear and a display-freeze (hold) so the board can read a stable value while counting continues.

---
 rtl/decade_display_pkg.sv | 35 +++
 rtl/decade_display_bcd_digit.sv | 22 ++
 rtl/decade_display.sv | 96 +++++++++
 3 files changed

// File: rtl/decade_display_pkg.sv
// Shared types, active-low seven-segment patterns and the BCD decoder.
package decade_pkg;

    typedef logic [3:0] bcd_t;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/decade_display_bcd_digit.sv
// One BCD digit of the accumulator; carry ripples combinationally to the next digit.
module bcd_digit
    import decade_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    assign cout = cin & (q == 4'd9);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (cin)
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end

endmodule

// File: rtl/decade_display.sv
// Edge-counting BCD accumulator with sticky overflow, freezeable display
// register and a multiplexed, leading-zero-blanked seven-segment driver.
module decade_display
    import decade_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              clr,
    input  logic              hold,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              ovf
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                    in_q;
    logic                    inc;
    logic [DIGITS:0]         carry;
    bcd_t [DIGITS-1:0]       cnt;
    bcd_t [DIGITS-1:0]       disp;
    logic [RW-1:0]           ref_cnt;
    logic [IW-1:0]           idx;
    logic [DIGITS-1:0]       live;
    bcd_t                    cur;
    logic                    blank;

    // in_q resets high so a level held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) in_q <= 1'b1;
        else     in_q <= in;
    end

    assign inc      = in & ~in_q;
    assign carry[0] = inc;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        bcd_digit u_dig (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr),
            .cin  (carry[k]),
            .q    (cnt[k]),
            .cout (carry[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || clr)         ovf <= 1'b0;
        else if (carry[DIGITS]) ovf <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) disp <= '0;
        else if (!hold) disp <= cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // live[k]: digit k or some higher digit is non-zero.
    always_comb begin
        live = '0;
        live[DIGITS-1] = (disp[DIGITS-1] != 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--)
            live[k] = live[k+1] | (disp[k] != 4'd0);
    end

    assign cur   = disp[idx];
    assign blank = (idx != '0) && !live[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= ~DIGITS'(1);
            seg <= SEG_0;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= blank ? SEG_BLANK : bcd_to_seg(cur);
        end
    end

endmodule
